// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default frame geometry,
// FSM state encoding and the per-frame line configuration.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OVS_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Line settings frozen for the duration of one frame.
  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } rx_cfg_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from the same edge and form a true 2-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detection, mid-bit sampling of data,
// optional parity and 1/2 stop bits, with a one-entry valid/ready output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic              rx_in,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int TICK_W = $clog2(OVS);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  logic rx_s;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  rx_state_t         state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              stop_cnt, stop_n;
  rx_cfg_t           cfg_q, cfg_n;
  logic              perr_q, perr_n;
  logic              ferr_q, ferr_n;
  logic              done;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    stop_n  = stop_cnt;
    cfg_n   = cfg_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    done    = 1'b0;

    if (baud_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end

        ST_START: begin
          if (tick_cnt == TICK_HALF) begin
            tick_n = '0;
            if (rx_s) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
              bit_n   = '0;
              cfg_n   = '{parity_en: parity_en, parity_odd: parity_odd, stop2: stop2};
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_cnt == TICK_FULL) begin
            tick_n  = '0;
            shift_n = {rx_s, shift_q[DATA_W-1:1]};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_n = cfg_q.parity_en ? ST_PARITY : ST_STOP;
              stop_n  = 1'b0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (tick_cnt == TICK_FULL) begin
            tick_n  = '0;
            perr_n  = rx_s ^ (^shift_q ^ cfg_q.parity_odd);
            state_n = ST_STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (tick_cnt == TICK_FULL) begin
            tick_n = '0;
            ferr_n = ferr_q | ~rx_s;
            // Leaving at mid-stop lets the next start edge be caught early.
            if (stop_cnt == cfg_q.stop2) begin
              state_n = ST_IDLE;
              done    = 1'b1;
            end else begin
              stop_n = 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      stop_cnt <= 1'b0;
      cfg_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      stop_cnt <= stop_n;
      cfg_q    <= cfg_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  // Single-entry output holding register with overrun on a busy slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data    <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_n;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames, expected results
// queued by the stimulus and compared by a monitor on each accepted frame.
module tb_uart_rx_core;

  localparam int BIT_CLK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic       rx_in;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt  = 0;

  uart_rx_core #(.DATA_W(8), .OVS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .rx_in       (rx_in),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .stop2       (stop2),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of both edges.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic s2en, input logic st1,
                            input logic st2, input logic flip);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2en;
    rx_in      = 1'b0;
    tick(BIT_CLK);
    if (flip) begin
      parity_en  = ~pen;
      parity_odd = ~podd;
      stop2      = ~s2en;
    end
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(BIT_CLK);
    end
    if (pen) begin
      rx_in = pbit;
      tick(BIT_CLK);
    end
    rx_in = st1;
    tick(BIT_CLK);
    if (s2en) begin
      rx_in = st2;
      tick(BIT_CLK);
    end
    rx_in      = 1'b1;
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2en;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_q.push_back('{data: d, perr: perr, ferr: ferr});
  endtask

  // Monitor: every accepted frame must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && overrun_err) ovr_cnt++;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_queue_size", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_data", {24'h0, rx_data}, {24'h0, e.data});
        check("frame_parity_err", {31'h0, parity_err}, {31'h0, e.perr});
        check("frame_frame_err", {31'h0, frame_err}, {31'h0, e.ferr});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    baud_tick  = 1'b1;
    rx_in      = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    rx_ready   = 1'b1;
    tick(3);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_rx_valid", {31'h0, rx_valid}, 0);
    check("reset_rx_data", {24'h0, rx_data}, 0);
    check("reset_errs", {29'h0, parity_err, frame_err, overrun_err}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // 8N1 clean frame
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(20);

    // Even parity: wrong then right parity bit (0xA3 has four ones)
    expect_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(20);
    expect_frame(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(20);

    // Odd parity, 0x01 has one 1 so correct bit is 0; send 1
    expect_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(20);

    // Single stop bit low, then second of two stop bits low
    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(40);
    expect_frame(8'hC3, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(40);
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(20);

    // Start glitch: 4 clk low, must be rejected within 8 clk
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    check("glitch_busy_rise", {31'h0, busy}, 1);
    for (int i = 0; i < 8 && busy; i++) @(negedge clk);
    check("glitch_busy_fall", {31'h0, busy}, 0);
    tick(40);

    // Overrun: two frames back-to-back with consumer stalled
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(30);
    @(negedge clk);
    check("overrun_valid_held", {31'h0, rx_valid}, 1);
    check("overrun_data_held", {24'h0, rx_data}, 32'h11);
    check("overrun_pulse_cycles", ovr_cnt, 1);
    tick(1);
    rx_ready = 1'b1;
    tick(20);

    // Reset during data bit 3 of 0x7E abandons the frame
    parity_en = 1'b0;
    stop2     = 1'b0;
    rx_in     = 1'b0;
    tick(BIT_CLK);
    rx_in = 1'b0; tick(BIT_CLK);
    rx_in = 1'b1; tick(BIT_CLK);
    rx_in = 1'b1; tick(BIT_CLK);
    rx_in = 1'b1; tick(8);
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    check("midframe_reset_busy", {31'h0, busy}, 0);
    check("midframe_reset_valid", {31'h0, rx_valid}, 0);
    check("midframe_reset_data", {24'h0, rx_data}, 0);
    tick(1);
    rx_in = 1'b1;
    rst_n = 1'b1;
    tick(40);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
